fp16_to_intn_packer: RTL and testbench

- Streaming converter from IEEE-754 binary16 values to signed INT_WIDTH-bit integers. It is the inverse of the intN-to-fp16 path.
- Uses round-to-nearest-even with saturation.
- Packs PACK_NUM converted lanes into one output word for the streamer/TCDM write path.
- Valid/ready handshake on both sides. One element per cycle sustained.

---
 rtl/fp16_to_intn_packer.sv | 167 ++++++++++++++++
 tb/tb_fp16_to_intn_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_intn_packer.sv
// fp16_to_intn_packer: streams IEEE-754 binary16 values, converts each to a
// signed INT_WIDTH-bit integer (round-to-nearest-even, saturating) and packs
// PACK_NUM lanes per output word. Lane k sits at [k*INT_WIDTH +: INT_WIDTH].
// Optional sticky saturation/NaN status: define FP16_TO_INTN_STATUS_EN.
module fp16_to_intn_packer #(
  parameter int unsigned INT_WIDTH = 4,
  parameter int unsigned PACK_NUM  = 8,
  localparam int unsigned OW = INT_WIDTH * PACK_NUM,
  localparam int unsigned LW = $clog2(PACK_NUM + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [15:0]   fp16_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          flush_i,
  output logic [OW-1:0] out_data_o,
  output logic [LW-1:0] out_lanes_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
`ifdef FP16_TO_INTN_STATUS_EN
  ,
  input  logic          clear_flags_i,
  output logic          sat_flag_o,
  output logic          nan_flag_o
`endif
);

  localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [11:0] POS_LIM = 12'((1 << (INT_WIDTH - 1)) - 1);
  localparam logic [11:0] NEG_LIM = 12'(1 << (INT_WIDTH - 1));
  localparam logic [4:0]  EXP_SAT = 5'(15 + INT_WIDTH);

  logic                 sgn;
  logic [4:0]           expo;
  logic [9:0]           mant;
  logic [4:0]           shamt;
  logic [21:0]          ext;
  logic                 rnd_up;
  logic [11:0]          mag;
  logic [INT_WIDTH-1:0] conv_val;
  logic                 conv_sat;
  logic                 conv_nan;

  logic [OW-1:0]        acc;
  logic [LW-1:0]        cnt;
  logic                 accept_el;
  logic                 accept_fl;
  logic [OW-1:0]        word_next;
  logic [LW-1:0]        lanes_next;
  logic                 emit;

  // fp16 -> saturated INT_WIDTH conversion of the presented element.
  // The significand is shifted right with its fraction bits kept below the
  // binary point so guard/sticky are available for ties-to-even; the range
  // check uses the full magnitude, before truncation to INT_WIDTH bits.
  always_comb begin
    sgn      = fp16_i[15];
    expo     = fp16_i[14:10];
    mant     = fp16_i[9:0];
    shamt    = 5'd25 - expo;
    ext      = {1'b1, mant, 11'b0} >> shamt;
    rnd_up   = ext[10] && ((|ext[9:0]) || ext[11]);
    mag      = {1'b0, ext[21:11]} + 12'(rnd_up);
    conv_val = '0;
    conv_sat = 1'b0;
    conv_nan = 1'b0;
    if (expo == 5'd0) begin
      conv_val = '0;
    end else if (expo == 5'd31) begin
      if (mant == 10'd0) begin
        conv_sat = 1'b1;
        conv_val = sgn ? INT_MIN : INT_MAX;
      end else begin
        conv_nan = 1'b1;
      end
    end else if (expo >= EXP_SAT) begin
      conv_sat = 1'b1;
      conv_val = sgn ? INT_MIN : INT_MAX;
    end else if (expo < 5'd14) begin
      conv_val = '0;
    end else if (!sgn) begin
      if (mag > POS_LIM) begin
        conv_sat = 1'b1;
        conv_val = INT_MAX;
      end else begin
        conv_val = mag[INT_WIDTH-1:0];
      end
    end else begin
      if (mag > NEG_LIM) begin
        conv_sat = 1'b1;
        conv_val = INT_MIN;
      end else begin
        conv_val = -mag[INT_WIDTH-1:0];
      end
    end
  end

  assign in_ready_o = !(out_valid_o && !out_ready_i);

  // Merge the accepted element into the word and decide whether to emit it.
  // A flush in the same cycle as an element sees the element already merged,
  // so a completing element plus flush yields one full word.
  always_comb begin
    accept_el  = in_valid_i && in_ready_o;
    accept_fl  = flush_i && in_ready_o;
    word_next  = acc;
    for (int unsigned k = 0; k < PACK_NUM; k++) begin
      if (accept_el && (cnt == LW'(k))) begin
        word_next[k*INT_WIDTH +: INT_WIDTH] = conv_val;
      end
    end
    lanes_next = cnt + LW'(accept_el);
    emit       = (accept_el && (cnt == LW'(PACK_NUM - 1))) ||
                 (accept_fl && (lanes_next != '0));
  end

  // Accumulator and lane counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc <= '0;
      cnt <= '0;
    end else if (emit) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept_el) begin
      acc <= word_next;
      cnt <= lanes_next;
    end
  end

  // Output register: loads on emit (also replacing a word being drained),
  // otherwise holds until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_o  <= '0;
      out_lanes_o <= '0;
      out_valid_o <= 1'b0;
    end else if (emit) begin
      out_data_o  <= word_next;
      out_lanes_o <= lanes_next;
      out_valid_o <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef FP16_TO_INTN_STATUS_EN
  // Sticky status flags; a set event beats a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_flag_o <= 1'b0;
      nan_flag_o <= 1'b0;
    end else begin
      if (accept_el && conv_sat) sat_flag_o <= 1'b1;
      else if (clear_flags_i)    sat_flag_o <= 1'b0;
      if (accept_el && conv_nan) nan_flag_o <= 1'b1;
      else if (clear_flags_i)    nan_flag_o <= 1'b0;
    end
  end
`else
  logic unused_status;
  assign unused_status = conv_sat ^ conv_nan;
`endif

endmodule

// File: tb/tb_fp16_to_intn_packer.sv
// Self-checking bench for fp16_to_intn_packer (INT_WIDTH=4, PACK_NUM=8).
module tb_fp16_to_intn_packer;

  localparam int W = 4;
  localparam int P = 8;

  logic        clk;
  logic        rst_ni;
  logic [15:0] fp16_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        flush_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_lanes_o;
  logic        out_valid_o;
  logic        out_ready_i;
`ifdef FP16_TO_INTN_STATUS_EN
  logic        clear_flags_i;
  logic        sat_flag_o;
  logic        nan_flag_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_cnt;
  int          m_lane [P];
  bit          m_pend;
  bit          m_sat;
  bit          m_nan;
  logic [35:0] exp_q [$];
  logic [35:0] got_q [$];

  logic [15:0] vec1 [8] = '{16'h3C00, 16'h4000, 16'h3800, 16'h3E00,
                            16'h4100, 16'hBC00, 16'h4800, 16'hC800};
  logic [15:0] vec2 [8] = '{16'hC100, 16'hB800, 16'h7C00, 16'hFC00,
                            16'h7E00, 16'h0001, 16'h3A00, 16'h3400};
  logic [15:0] specials [12] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                 16'h7E01, 16'h3800, 16'h3A00, 16'h4100,
                                 16'h4700, 16'h4780, 16'hC800, 16'hC880};

  fp16_to_intn_packer #(.INT_WIDTH(W), .PACK_NUM(P)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .fp16_i      (fp16_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .out_data_o  (out_data_o),
    .out_lanes_o (out_lanes_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef FP16_TO_INTN_STATUS_EN
    ,
    .clear_flags_i (clear_flags_i),
    .sat_flag_o    (sat_flag_o),
    .nan_flag_o    (nan_flag_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every word actually handed to the consumer.
  always @(negedge clk) begin
    if (rst_ni && out_valid_o && out_ready_i) got_q.push_back({out_lanes_o, out_data_o});
  end

  // Real-valued conversion straight from the numeric definition.
  task automatic ref_conv(input logic [15:0] h, output int val, output bit sat, output bit nan);
    int  e, m, r;
    real v, p2, fl, fr;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    val = 0; sat = 0; nan = 0;
    if (e == 0) begin
      val = 0;
    end else if (e == 31) begin
      if (m == 0) begin sat = 1; val = h[15] ? -(1 << (W-1)) : (1 << (W-1)) - 1; end
      else nan = 1;
    end else begin
      p2 = 1.0;
      for (int i = 0; i < (e > 25 ? e - 25 : 25 - e); i++) p2 = p2 * 2.0;
      if (e < 25) p2 = 1.0 / p2;
      v  = (1024.0 + m) * p2;
      fl = $floor(v);
      fr = v - fl;
      r  = int'(fl);
      if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r = r + 1;
      if (h[15]) r = -r;
      if (r > (1 << (W-1)) - 1) begin sat = 1; r = (1 << (W-1)) - 1; end
      if (r < -(1 << (W-1)))    begin sat = 1; r = -(1 << (W-1)); end
      val = r;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pend = 0; m_sat = 0; m_nan = 0;
    for (int k = 0; k < P; k++) m_lane[k] = 0;
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic step(input bit v, input logic [15:0] d, input bit f, input bit r, input bit clr);
    bit acc, emit, s, n;
    int val;
    logic [31:0] w;
    in_valid_i = v; fp16_i = d; flush_i = f; out_ready_i = r;
`ifdef FP16_TO_INTN_STATUS_EN
    clear_flags_i = clr;
`endif
    #1;
    acc = !(m_pend && !r);
    emit = 0; s = 0; n = 0;
    if (acc && v) begin
      ref_conv(d, val, s, n);
      m_lane[m_cnt] = val;
      m_cnt++;
      if (m_cnt == P) emit = 1;
    end
    if (clr) begin m_sat = s; m_nan = n; end
    else begin m_sat = m_sat | s; m_nan = m_nan | n; end
    if (acc && f && m_cnt > 0) emit = 1;
    if (emit) begin
      w = '0;
      for (int k = 0; k < m_cnt; k++) w[k*W +: W] = 4'(m_lane[k]);
      exp_q.push_back({4'(m_cnt), w});
      m_cnt = 0;
      for (int k = 0; k < P; k++) m_lane[k] = 0;
      m_pend = 1;
    end else if (r) begin
      m_pend = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 1, 0);
  endtask

  task automatic test_reset();
    rst_ni = 0; in_valid_i = 0; fp16_i = 0; flush_i = 0; out_ready_i = 1;
`ifdef FP16_TO_INTN_STATUS_EN
    clear_flags_i = 0;
`endif
    model_reset();
    #12;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid_o); end
    n_checks++; if (out_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 00000000", out_data_o); end
    n_checks++; if (out_lanes_o !== 4'h0) begin n_fail++; $display("FAIL reset_lanes got %0d exp 0", out_lanes_o); end
    @(posedge clk); #1;
    rst_ni = 1;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", in_ready_o); end
`ifdef FP16_TO_INTN_STATUS_EN
    n_checks++; if (sat_flag_o !== 1'b0 || nan_flag_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", sat_flag_o, nan_flag_o); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_stream_basic();
    idle(2); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) begin
      step(1, vec1[i], 0, 1, 0);
      if (i == 6) begin
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %0b exp 0", out_valid_o); end
      end
    end
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %0b exp 1", out_valid_o); end
    n_checks++; if (out_data_o !== 32'h87F22021) begin n_fail++; $display("FAIL basic_data got %h exp 87f22021", out_data_o); end
    n_checks++; if (out_lanes_o !== 4'd8) begin n_fail++; $display("FAIL basic_lanes got %0d exp 8", out_lanes_o); end
    n_checks++; if (exp_q.size() != 1 || exp_q[0] !== {4'd8, out_data_o}) begin n_fail++; $display("FAIL basic_model got %h exp %h", out_data_o, exp_q.size() > 0 ? exp_q[0][31:0] : 32'hx); end
    idle(2);
  endtask

  task automatic test_rounding_special();
    step(0, 16'h0, 0, 1, 1);
    idle(1); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) step(1, vec2[i], 0, 1, 0);
    n_checks++; if (out_data_o !== 32'h0100870E) begin n_fail++; $display("FAIL special_data got %h exp 0100870e", out_data_o); end
    n_checks++; if (out_lanes_o !== 4'd8) begin n_fail++; $display("FAIL special_lanes got %0d exp 8", out_lanes_o); end
`ifdef FP16_TO_INTN_STATUS_EN
    n_checks++; if (sat_flag_o !== 1'b1) begin n_fail++; $display("FAIL special_sat got %0b exp 1", sat_flag_o); end
    n_checks++; if (nan_flag_o !== 1'b1) begin n_fail++; $display("FAIL special_nan got %0b exp 1", nan_flag_o); end
    step(0, 16'h0, 0, 1, 1);
    n_checks++; if (sat_flag_o !== 1'b0 || nan_flag_o !== 1'b0) begin n_fail++; $display("FAIL flags_clear got %b%b exp 00", sat_flag_o, nan_flag_o); end
`endif
    idle(2);
  endtask

  task automatic test_flush();
    idle(1); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 3; i++) step(1, 16'h4000, 0, 1, 0);
    step(0, 16'h0, 1, 1, 0);
    n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %0b exp 1", out_valid_o); end
    n_checks++; if (out_data_o !== 32'h00000222) begin n_fail++; $display("FAIL flush_data got %h exp 00000222", out_data_o); end
    n_checks++; if (out_lanes_o !== 4'd3) begin n_fail++; $display("FAIL flush_lanes got %0d exp 3", out_lanes_o); end
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 1, 1, 0);
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %0b exp 0", out_valid_o); end
    idle(2);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL flush_count got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_flush_with_last();
    idle(1); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 7; i++) step(1, 16'h4000, 0, 1, 0);
    step(1, 16'h4000, 1, 1, 0);
    n_checks++; if (out_lanes_o !== 4'd8) begin n_fail++; $display("FAIL flushlast_lanes got %0d exp 8", out_lanes_o); end
    n_checks++; if (out_data_o !== 32'h22222222) begin n_fail++; $display("FAIL flushlast_data got %h exp 22222222", out_data_o); end
    step(0, 16'h0, 0, 1, 0);
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL flushlast_extra got %0b exp 0", out_valid_o); end
    idle(2);
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL flushlast_count got %0d exp 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    idle(1); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) step(1, vec1[i], 0, 0, 0);
    n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %0b exp 0", in_ready_o); end
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h4000, 0, 0, 0);
      n_checks++; if (out_data_o !== 32'h87F22021 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold got %h/%0b exp 87f22021/1", out_data_o, out_valid_o); end
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 16'(16'h3C00 + 16'(i * 16'h0100)), 0, 1, 0);
      if (i == 7 || i == 15) begin
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d got %0b exp 1", i, out_valid_o); end
      end
    end
    idle(3);
    n_checks++; if (got_q.size() != 3 || exp_q.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word_%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 16'h4000, 0, 1, 0);
    rst_ni = 0; #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_partial got %0b exp 0", out_valid_o); end
    model_reset(); exp_q.delete(); got_q.delete();
    @(posedge clk); #1; rst_ni = 1;
    for (int i = 0; i < 8; i++) step(1, vec1[i], 0, 1, 0);
    idle(2);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== {4'd8, 32'h87F22021}) begin n_fail++; $display("FAIL rstmid_word got %0d words exp 1 word 87f22021", got_q.size()); end
    for (int i = 0; i < 8; i++) step(1, 16'h4000, 0, 0, 0);
    rst_ni = 0; #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got %0b exp 0", out_valid_o); end
    model_reset(); exp_q.delete(); got_q.delete();
    @(posedge clk); #1; rst_ni = 1;
    idle(4);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rstmid_ghost got %0d words exp 0", got_q.size()); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    idle(1); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) d = specials[$urandom_range(0, 11)];
      else d = 16'($urandom);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
`ifdef FP16_TO_INTN_STATUS_EN
    n_checks++; if (sat_flag_o !== m_sat || nan_flag_o !== m_nan) begin n_fail++; $display("FAIL rand_flags got %b%b exp %b%b", sat_flag_o, nan_flag_o, m_sat, m_nan); end
`endif
    step(0, 16'h0, 1, 1, 0);
    idle(3);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word_%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_rounding_special();
    test_flush();
    test_flush_with_last();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
